tr_tracker: RTL and testbench

Closed-loop position tracker that compares an ADC sample `x` against a setpoint `x0` and drives a step/direction stepper-motor driver to null the error. Error magnitude is classified against two thresholds into a dead zone, a slow-step band and a fast-step band. The block sits between the ADC capture logic, which supplies `data_valid` strobes, and the external stepper driver pins.

---
 rtl/tr_pkg.sv | 24 ++
 rtl/tr_step_gen.sv | 82 ++++++++
 rtl/tr_tracker.sv | 95 +++++++++
 tb/tb_tr_tracker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared widths, state encoding and default timing constants for the tr_tracker slice.
package tr_pkg;

  localparam int unsigned X_W   = 12;
  localparam int unsigned E_W   = 13;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned SLOW_PERIOD_DEF = 60;
  localparam int unsigned FAST_PERIOD_DEF = 6;
  localparam int unsigned PULSE_W_DEF     = 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SLOW,
    FAST
  } tr_state_e;

  // |e| of a 13-bit signed error; the most negative reachable value is -4095, so 12 bits suffice.
  function automatic logic [X_W-1:0] err_abs(input logic [E_W-1:0] e);
    return e[E_W-1] ? (~e[X_W-1:0] + {{(X_W-1){1'b0}}, 1'b1}) : e[X_W-1:0];
  endfunction

endpackage

// File: rtl/tr_step_gen.sv
// Step/direction pulse generator: period counter, pulse width and direction setup.
module tr_step_gen
  import tr_pkg::*;
#(
  parameter int unsigned PULSE_W = PULSE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic             dir_req,
  output logic             drv_step,
  output logic             drv_dir
);

  localparam int unsigned PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PW_W-1:0]  PwOne  = {{(PW_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             first_q, first_d;
  logic             dir_chg, start;

  always_comb begin
    // Direction may only move while the step line is low; a pending change blocks stepping.
    dir_chg = !step_q && (dir_req != dir_q);
    dir_d   = dir_chg ? dir_req : dir_q;
    start   = run && !step_q && (dir_req == dir_q) &&
              (first_q || (cnt_q >= (period - CntOne)));

    step_d = step_q;
    pw_d   = pw_q;
    if (start) begin
      step_d = 1'b1;
      pw_d   = PW_W'(PULSE_W - 1);
    end else if (step_q) begin
      if (pw_q == '0) begin
        step_d = 1'b0;
      end else begin
        pw_d = pw_q - PwOne;
      end
    end

    // first_q requests an immediate step on entry into a stepping zone.
    cnt_d   = cnt_q;
    first_d = first_q;
    if (!run) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (start) begin
      cnt_d   = '0;
      first_d = 1'b0;
    end else if (dir_chg) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pw_q    <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      first_q <= first_d;
    end
  end

  assign drv_step = step_q;
  assign drv_dir  = dir_q;

endmodule

// File: rtl/tr_tracker.sv
// Closed-loop position tracker driving a step/dir stepper driver from ADC samples.
// Optional macro TR_DEADZONE_EN: when defined, |e| <= dx1 is a true dead zone (no steps).
module tr_tracker
  import tr_pkg::*;
#(
  parameter int unsigned SLOW_PERIOD = SLOW_PERIOD_DEF,
  parameter int unsigned FAST_PERIOD = FAST_PERIOD_DEF,
  parameter int unsigned PULSE_W     = PULSE_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x,
  input  logic [X_W-1:0] x0,
  input  logic           data_valid,
  input  logic           enable,
  input  logic [X_W-1:0] dx1,
  input  logic [X_W-1:0] dx2,
  output logic           drv_SM,
  output logic           drv_step,
  output logic           drv_dir
);

  logic [E_W-1:0]   e;
  logic [X_W-1:0]   e_abs;
  logic             accept, e_zero, e_pos;
  logic             dir_q, dir_req, run;
  logic [CNT_W-1:0] period;
  tr_state_e        state_q, state_d, zone;

  assign accept = data_valid && enable;
  assign e      = {1'b0, x} - {1'b0, x0};
  assign e_abs  = err_abs(e);
  assign e_zero = (e == '0);
  assign e_pos  = !e[E_W-1] && !e_zero;

  always_comb begin
    zone = HOLD;
    if (e_abs > dx2) begin
      zone = FAST;
`ifdef TR_DEADZONE_EN
    end else if (e_abs > dx1) begin
`else
    end else if (!e_zero) begin
`endif
      zone = SLOW;
    end
  end

`ifndef TR_DEADZONE_EN
  logic unused_dx1;
  assign unused_dx1 = ^dx1;
`endif

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = zone;
    end else if (state_q == IDLE) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !e_zero) begin
        dir_q <= e_pos;
      end
    end
  end

  // Present the new sign on the accept cycle so drv_dir settles before the first step.
  assign dir_req = (accept && !e_zero) ? e_pos : dir_q;
  assign run     = enable && ((state_q == SLOW) || (state_q == FAST));
  assign period  = (state_q == FAST) ? CNT_W'(FAST_PERIOD) : CNT_W'(SLOW_PERIOD);
  assign drv_SM  = (state_q != IDLE);

  tr_step_gen #(
    .PULSE_W(PULSE_W)
  ) u_step_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .period  (period),
    .dir_req (dir_req),
    .drv_step(drv_step),
    .drv_dir (drv_dir)
  );

endmodule

// File: tb/tb_tr_tracker.sv
// Directed, table-driven bench for tr_tracker (default parameters 60/6/1).
module tb_tr_tracker;

`ifdef TR_DEADZONE_EN
  localparam bit Dz = 1'b1;
`else
  localparam bit Dz = 1'b0;
`endif
  localparam int Win = 130;

  logic        clk;
  logic        rst, data_valid, enable;
  logic [11:0] x, x0, dx1, dx2;
  logic        drv_SM, drv_step, drv_dir;

  tr_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x0        (x0),
    .data_valid(data_valid),
    .enable    (enable),
    .dx1       (dx1),
    .dx2       (dx2),
    .drv_SM    (drv_SM),
    .drv_step  (drv_step),
    .drv_dir   (drv_dir)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor runs just after each rising edge; the main thread works on falling edges.
  logic step_prev = 1'b0;
  logic dir_prev  = 1'b0;
  int   rise_count = 0, first_rise = -1, prev_rise = -1, last_rise = -1;
  int   dir_viol = 0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (drv_dir !== dir_prev && (step_prev || drv_step)) dir_viol++;
      if (drv_step && !step_prev) begin
        rise_count++;
        if (first_rise < 0) first_rise = cyc;
        prev_rise = last_rise;
        last_rise = cyc;
      end
    end
    step_prev = drv_step;
    dir_prev  = drv_dir;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_count = 0;
    first_rise = -1;
    prev_rise  = -1;
    last_rise  = -1;
  endtask

  // Present one sample for one cycle; acc is the index of the edge that captures it.
  task automatic sample(input int xs, input int x0s, input int d1, input int d2);
    x = 12'(xs); x0 = 12'(x0s); dx1 = 12'(d1); dx2 = 12'(d2);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    acc = cyc;
  endtask

  typedef struct {
    bit          en;
    int          xs, x0s, d1, d2;
    int          sm, dir, steps, gap;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input bit en, input int xs, input int x0s, input int d1,
                              input int d2, input int sm, input int dir, input int steps,
                              input int gap);
    vec_t v;
    v.en = en; v.xs = xs; v.x0s = x0s; v.d1 = d1; v.d2 = d2;
    v.sm = sm; v.dir = dir; v.steps = steps; v.gap = gap;
    return v;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; data_valid = 1'b0;
    x = '0; x0 = '0; dx1 = '0; dx2 = '0;

    // Window of 130 edges after the sample: SLOW rises at +1,+61,+121; FAST every 6 from +1.
    vecs.push_back(mk(1, 25, 5, 10, 100, 1, 1, 3, 60));
    vecs.push_back(mk(1, 200, 5, 10, 100, 1, 1, 22, 6));
    vecs.push_back(mk(1, 5, 400, 10, 100, 1, 0, 22, 6));
    vecs.push_back(mk(1, 6, 5, 10, 100, 1, 1, Dz ? 0 : 3, 60));
    vecs.push_back(mk(1, 0, 5, 10, 100, 1, 0, Dz ? 0 : 3, 60));
    vecs.push_back(mk(1, 105, 5, 10, 100, 1, 1, 3, 60));
    vecs.push_back(mk(1, 106, 5, 10, 100, 1, 1, 22, 6));
    vecs.push_back(mk(1, 15, 5, 10, 100, 1, 1, Dz ? 0 : 3, 60));
    vecs.push_back(mk(1, 16, 5, 10, 100, 1, 1, 3, 60));
    vecs.push_back(mk(0, 200, 5, 10, 100, 0, 1, 0, 0));
    vecs.push_back(mk(1, 35, 5, 50, 20, 1, 1, 22, 6));
    vecs.push_back(mk(1, 20, 5, 50, 20, 1, 1, Dz ? 0 : 3, 60));
    vecs.push_back(mk(1, 4095, 0, 10, 100, 1, 1, 22, 6));
    vecs.push_back(mk(1, 0, 4095, 10, 100, 1, 0, 22, 6));
    vecs.push_back(mk(1, 10, 5, 10, 100, 1, 1, Dz ? 0 : 3, 60));

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset_sm", drv_SM, 0);
    check("reset_step", drv_step, 0);
    check("reset_dir", drv_dir, 0);
    rst = 1'b0;

    // Enable held low for 300 cycles with periodic data_valid: nothing may happen.
    begin
      int sm_seen;
      sm_seen = 0;
      clear_mon();
      x = 12'd200; x0 = 12'd5; dx1 = 12'd10; dx2 = 12'd100;
      for (int i = 0; i < 300; i++) begin
        data_valid = (i % 5 == 0);
        @(negedge clk);
        if (drv_SM) sm_seen = 1;
      end
      data_valid = 1'b0;
      check("gated_sm", sm_seen, 0);
      check("gated_steps", rise_count, 0);
    end
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("enable_hold_sm", drv_SM, 1);
    check("enable_hold_steps", rise_count, 0);
    sample(200, 5, 10, 100);
    clear_mon();
    repeat (4) @(negedge clk);
    // acc-1 is the cycle the sample was presented in; first rise two cycles later.
    check("enable_first_lat", first_rise - (acc - 1), 2);
    check("enable_first_dir", drv_dir, 1);

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      sample(vecs[i].x0s, vecs[i].x0s, vecs[i].d1, vecs[i].d2);
      repeat (3) @(negedge clk);
      sample(vecs[i].xs, vecs[i].x0s, vecs[i].d1, vecs[i].d2);
      clear_mon();
      repeat (Win) @(negedge clk);
      check($sformatf("vec%0d_sm", i), drv_SM, vecs[i].sm);
      check($sformatf("vec%0d_dir", i), drv_dir, vecs[i].dir);
      check($sformatf("vec%0d_steps", i), rise_count, vecs[i].steps);
      if (vecs[i].steps > 0)
        check($sformatf("vec%0d_lat", i), first_rise - (acc - 1), 2);
      if (vecs[i].steps > 1)
        check($sformatf("vec%0d_gap", i), last_rise - prev_rise, vecs[i].gap);
    end

    // Reversal inside FAST: dir flips, next step at least one cycle after, spacing 6 again.
    enable = 1'b1;
    sample(5, 5, 10, 100);
    repeat (3) @(negedge clk);
    sample(200, 5, 10, 100);
    repeat (20) @(negedge clk);
    sample(200, 400, 10, 100);
    clear_mon();
    for (int i = 0; i < 40 && rise_count < 2; i++) @(negedge clk);
    check("rev_two_steps", (rise_count >= 2), 1);
    check("rev_dir", drv_dir, 0);
    check("rev_after_change", (first_rise >= acc + 1), 1);
    check("rev_gap", last_rise - prev_rise, 6);

    // SLOW to FAST with the counter already past the fast compare: step on the next cycle.
    sample(5, 5, 10, 100);
    repeat (3) @(negedge clk);
    sample(25, 5, 10, 100);
    repeat (30) @(negedge clk);
    sample(200, 5, 10, 100);
    clear_mon();
    repeat (12) @(negedge clk);
    check("s2f_next_cycle", first_rise - acc, 1);
    check("s2f_steps", rise_count, 2);
    check("s2f_gap", last_rise - prev_rise, 6);

    // Enable falling edge while stepping fast.
    enable = 1'b0;
    clear_mon();
    @(negedge clk);
    check("endrop_sm", drv_SM, 0);
    repeat (20) @(negedge clk);
    check("endrop_steps", rise_count, 0);

    // Reset asserted mid-pulse while in FAST.
    enable = 1'b1;
    sample(200, 5, 10, 100);
    begin
      int waited;
      waited = 0;
      while (!drv_step && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("rst_wait_pulse", drv_step, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_step", drv_step, 0);
    check("rst_sm", drv_SM, 0);
    check("rst_dir", drv_dir, 0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_hold_sm", drv_SM, 1);
    repeat (10) @(negedge clk);
    check("rst_hold_steps", rise_count, 0);
    sample(200, 5, 10, 100);
    clear_mon();
    repeat (10) @(negedge clk);
    check("rst_resume_lat", first_rise - (acc - 1), 2);
    check("rst_resume_dir", drv_dir, 1);
    check("rst_resume_steps", rise_count, 2);

    check("dir_setup_rule", dir_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
